// File: rtl/mcy_dual_core_comparator.sv
// Cycle-by-cycle equivalence monitor between a golden and a mutated core, with first-divergence capture.
// Optional macro MCY_CMP_CAPTURE_EN adds the golden/mutated values of the first diverging channel.
module mcy_dual_core_comparator #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 32,
  parameter int WARMUP     = 8,
  parameter int MAX_CYCLES = 1024,
  parameter int CNT_W      = 16,
  localparam int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [NUM_CH-1:0]      ch_valid_i,
  input  logic [NUM_CH*CH_W-1:0] golden_i,
  input  logic [NUM_CH*CH_W-1:0] mutated_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   mismatch_o,
  output logic [CH_IDX_W-1:0]    mismatch_ch_o,
  output logic [CNT_W-1:0]       mismatch_cycle_o,
  output logic [CNT_W-1:0]       cycle_o
`ifdef MCY_CMP_CAPTURE_EN
  ,
  output logic [CH_W-1:0]        mismatch_golden_o,
  output logic [CH_W-1:0]        mismatch_mutated_o
`endif
);

  // state   | meaning
  // S_IDLE  | no run; captured fields cleared, waiting for start
  // S_ARMED | warmup, counter runs, no compare
  // S_COMP  | comparing valid channels every cycle
  // S_FAIL  | divergence seen; verdict fail, fields held until start
  // S_DONE  | run length reached cleanly; verdict pass
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_COMP, S_FAIL, S_DONE} state_e;

  localparam logic [CNT_W-1:0] WARM_END = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] MAX_END  = CNT_W'(MAX_CYCLES - 1);
  localparam state_e           RUN_ST   = (WARMUP == 0) ? S_COMP : S_ARMED;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  mm_q, mm_d;
  logic [CH_IDX_W-1:0]   mm_ch_q, mm_ch_d;
  logic [CNT_W-1:0]      mm_cyc_q, mm_cyc_d;
`ifdef MCY_CMP_CAPTURE_EN
  logic [CH_W-1:0]       cap_g_q, cap_g_d;
  logic [CH_W-1:0]       cap_m_q, cap_m_d;
`endif

  logic [NUM_CH-1:0]     diff;
  logic                  any_diff;
  logic [CH_IDX_W-1:0]   first_idx;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  start_go;

  // Invalid channels are masked before the compare result is used, so X there never propagates.
  always_comb begin
    diff      = '0;
    first_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      diff[k] = ch_valid_i[k] && (golden_i[k*CH_W +: CH_W] != mutated_i[k*CH_W +: CH_W]);
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (diff[k]) first_idx = CH_IDX_W'(k);
    end
    any_diff = |diff;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    start_go = start_i & ~abort_i;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mm_d     = mm_q;
    mm_ch_d  = mm_ch_q;
    mm_cyc_d = mm_cyc_q;
`ifdef MCY_CMP_CAPTURE_EN
    cap_g_d  = cap_g_q;
    cap_m_d  = cap_m_q;
`endif
    case (state_q)
      S_IDLE, S_FAIL, S_DONE: begin
        if (state_q == S_IDLE || start_go) begin
          done_d   = 1'b0;
          pass_d   = 1'b0;
          mm_d     = 1'b0;
          mm_ch_d  = '0;
          mm_cyc_d = '0;
`ifdef MCY_CMP_CAPTURE_EN
          cap_g_d  = '0;
          cap_m_d  = '0;
`endif
        end
        if (start_go) begin
          state_d = RUN_ST;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_ARMED: begin
        if (abort_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == WARM_END) state_d = S_COMP;
        end
      end
      S_COMP: begin
        if (abort_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (any_diff) begin
            state_d  = S_FAIL;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = 1'b0;
            mm_d     = 1'b1;
            mm_ch_d  = first_idx;
            mm_cyc_d = cnt_q;
`ifdef MCY_CMP_CAPTURE_EN
            cap_g_d  = golden_i[first_idx*CH_W +: CH_W];
            cap_m_d  = mutated_i[first_idx*CH_W +: CH_W];
`endif
          end else if (cnt_q == MAX_END) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mm_q     <= 1'b0;
      mm_ch_q  <= '0;
      mm_cyc_q <= '0;
`ifdef MCY_CMP_CAPTURE_EN
      cap_g_q  <= '0;
      cap_m_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
      mm_ch_q  <= mm_ch_d;
      mm_cyc_q <= mm_cyc_d;
`ifdef MCY_CMP_CAPTURE_EN
      cap_g_q  <= cap_g_d;
      cap_m_q  <= cap_m_d;
`endif
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign mismatch_o       = mm_q;
  assign mismatch_ch_o    = mm_ch_q;
  assign mismatch_cycle_o = mm_cyc_q;
  assign cycle_o          = cnt_q;
`ifdef MCY_CMP_CAPTURE_EN
  assign mismatch_golden_o  = cap_g_q;
  assign mismatch_mutated_o = cap_m_q;
`endif

endmodule

// File: tb/tb_mcy_dual_core_comparator.sv
// Directed bench for mcy_dual_core_comparator: NUM_CH=4, WARMUP=8, MAX_CYCLES=64.
module tb_mcy_dual_core_comparator;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 32;
  localparam int CNT_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   abort;
  logic [NUM_CH-1:0]      valid;
  logic [NUM_CH*CH_W-1:0] golden;
  logic [NUM_CH*CH_W-1:0] mutated;
  logic                   busy, done, pass, mm;
  logic [1:0]             mm_ch;
  logic [CNT_W-1:0]       mm_cyc, cyc_o;
`ifdef MCY_CMP_CAPTURE_EN
  logic [CH_W-1:0]        cap_g, cap_m;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mcy_dual_core_comparator #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .WARMUP(8), .MAX_CYCLES(64), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .ch_valid_i(valid), .golden_i(golden), .mutated_i(mutated),
    .busy_o(busy), .done_o(done), .pass_o(pass), .mismatch_o(mm),
    .mismatch_ch_o(mm_ch), .mismatch_cycle_o(mm_cyc), .cycle_o(cyc_o)
`ifdef MCY_CMP_CAPTURE_EN
    , .mismatch_golden_o(cap_g), .mismatch_mutated_o(cap_m)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      step();
      cyc++;
    end
  endtask

  task automatic clear_inputs();
    golden  = '0;
    mutated = '0;
    valid   = '1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    clear_inputs();
    #2 rst_n = 1'b0;
    #10;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mm", mm, 0);
    check("rst_cycle", cyc_o, 0);
    rst_n = 1'b1;
    step();

    // clean run
    start_run();
    check("t1_busy_armed", busy, 1);
    check("t1_cycle0", cyc_o, 0);
    run_to(63);
    check("t1_cycle63", cyc_o, 63);
    check("t1_not_done", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_busy", busy, 0);
    check("t1_mm", mm, 0);

    // channels 2 and 3 diverge at cycle 20
    start_run();
    check("t2_done_clr", done, 0);
    run_to(20);
    check("t2_mm_before", mm, 0);
    golden[2*CH_W +: CH_W]  = 32'h1234; mutated[2*CH_W +: CH_W] = 32'h1235;
    golden[3*CH_W +: CH_W]  = 32'h1234; mutated[3*CH_W +: CH_W] = 32'h1235;
    step();
    clear_inputs();
    check("t2_mm", mm, 1);
    check("t2_ch", mm_ch, 2);
    check("t2_cyc", mm_cyc, 20);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_busy", busy, 0);
    repeat (3) step();
    check("t2_hold_cyc", mm_cyc, 20);
    check("t2_hold_done", done, 1);

    // divergence confined to warmup, plus ignored start while busy
    start_run();
    check("t3_mm_clr", mm, 0);
    check("t3_done_clr", done, 0);
    golden[31:0] = 32'h1; mutated[31:0] = 32'h2;
    run_to(8);
    clear_inputs();
    run_to(20);
    start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    check("t3_start_ignored", cyc_o, 21);
    run_to(63);
    step();
    check("t3_pass", pass, 1);
    check("t3_mm", mm, 0);

    // first compared cycle is 8
    start_run();
    run_to(8);
    golden[31:0] = 32'h1; mutated[31:0] = 32'h2;
    step();
    clear_inputs();
    check("t3b_mm", mm, 1);
    check("t3b_cyc", mm_cyc, 8);
    check("t3b_ch", mm_ch, 0);

    // invalid channel (with X) ignored; then enabled at cycle 30
    valid = 4'b1101;
    golden[1*CH_W +: CH_W] = 32'h5; mutated[1*CH_W +: CH_W] = 'x;
    start_run();
    run_to(63);
    step();
    check("t4_pass", pass, 1);
    check("t4_mm", mm, 0);
    mutated[1*CH_W +: CH_W] = 32'h6;
    start_run();
    run_to(30);
    valid = 4'b1111;
    step();
    clear_inputs();
    check("t4_mm", mm, 1);
    check("t4_cyc", mm_cyc, 30);
    check("t4_ch", mm_ch, 1);

    // abort on the same cycle as a divergence
    start_run();
    run_to(15);
    golden[3*CH_W +: CH_W] = 32'hA; mutated[3*CH_W +: CH_W] = 32'hB;
    abort = 1'b1;
    step();
    abort = 1'b0;
    clear_inputs();
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_mm", mm, 0);
    step();
    check("t5_idle_busy", busy, 0);
    start_run();
    run_to(63);
    step();
    check("t5_rerun_done", done, 1);
    check("t5_rerun_pass", pass, 1);

    // asynchronous reset mid-run
    start_run();
    run_to(40);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_cycle", cyc_o, 0);
    check("t6_done", done, 0);
    check("t6_mm", mm, 0);
    rst_n = 1'b1;
    step();

`ifdef MCY_CMP_CAPTURE_EN
    start_run();
    run_to(12);
    golden[1*CH_W +: CH_W] = 32'hDEADBEEF; mutated[1*CH_W +: CH_W] = 32'hDEADBEEE;
    step();
    clear_inputs();
    check("cap_ch", mm_ch, 1);
    check("cap_golden", cap_g, 32'hDEADBEEF);
    check("cap_mutated", cap_m, 32'hDEADBEEE);
    start_run();
    check("cap_golden_clr", cap_g, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
